// File: rtl/onchip_flash_ctrl_pkg.sv
// Shared types and constants for the on-chip flash access controller.
// Optional line buffer is enabled with the ONCHIP_FLASH_LINE_BUF_EN macro.
package onchip_flash_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_REQ,
        WR_POLL,
        WR_WAIT,
        RESP
    } state_e;

    localparam logic CSR_STATUS  = 1'b0;
    localparam logic CSR_CONTROL = 1'b1;

    localparam int STATUS_BUSY_LSB = 0;
    localparam int STATUS_BUSY_MSB = 1;
    localparam int STATUS_WS       = 3;

    function automatic int burstcount_w(input int burst_len);
        return $clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/onchip_flash_line_buf.sv
// One-line read buffer (BURST_LEN words) with aligned tag, valid flag and
// write-hit invalidation; only instantiated when ONCHIP_FLASH_LINE_BUF_EN is set.
module onchip_flash_line_buf
    import onchip_flash_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [ADDR_WIDTH-1:0]              lookup_addr_i,
    output logic                               hit_o,
    output logic [DATA_WIDTH-1:0]              rdata_o,
    input  logic                               fill_en_i,
    input  logic [burstcount_w(BURST_LEN)-1:0] fill_idx_i,
    input  logic [DATA_WIDTH-1:0]              fill_data_i,
    input  logic                               fill_last_i,
    input  logic [ADDR_WIDTH-1:0]              fill_tag_i,
    input  logic                               inval_en_i,
    input  logic [ADDR_WIDTH-1:0]              inval_addr_i
);
    localparam int OFF_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] mem_q [BURST_LEN];
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    logic                  valid_q, valid_d;
    logic [OFF_W-1:0]      rd_idx, wr_idx;

    assign rd_idx  = OFF_W'(lookup_addr_i & OFF_MASK);
    assign wr_idx  = OFF_W'(fill_idx_i);
    assign hit_o   = valid_q && ((lookup_addr_i & ~OFF_MASK) == tag_q);
    assign rdata_o = mem_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (fill_en_i && fill_last_i) begin
            valid_d = 1'b1;
            tag_d   = fill_tag_i & ~OFF_MASK;
        end
        // A program into the buffered line makes the cached copy stale.
        if (inval_en_i && valid_q && ((inval_addr_i & ~OFF_MASK) == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            mem_q[wr_idx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/onchip_flash_ctrl.sv
// Request/response front end for the on-chip flash IP: burst reads, word programs
// with CSR status polling. Line buffer selected by ONCHIP_FLASH_LINE_BUF_EN.
module onchip_flash_ctrl
    import onchip_flash_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LEN    = 2,
    parameter int POLL_TIMEOUT = 4096
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_write,
    input  logic [ADDR_WIDTH-1:0]              req_addr,
    input  logic [DATA_WIDTH-1:0]              req_wdata,
    output logic                               rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               rsp_error,
    output logic [ADDR_WIDTH-1:0]              avmm_data_addr,
    output logic                               avmm_data_read,
    output logic                               avmm_data_write,
    output logic [DATA_WIDTH-1:0]              avmm_data_writedata,
    output logic [burstcount_w(BURST_LEN)-1:0] avmm_data_burstcount,
    input  logic [DATA_WIDTH-1:0]              avmm_data_readdata,
    input  logic                               avmm_data_waitrequest,
    input  logic                               avmm_data_readdatavalid,
    output logic                               avmm_csr_addr,
    output logic                               avmm_csr_read,
    input  logic [31:0]                        avmm_csr_readdata
);
    localparam int CNT_W = burstcount_w(BURST_LEN);
    localparam int PC_W  = $clog2(POLL_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BURST_LEN - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [PC_W-1:0]       poll_q, poll_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  buf_hit;
    logic [DATA_WIDTH-1:0] buf_rdata;
    logic                  unused_status;

    assign unused_status = ^{avmm_csr_readdata[31:4], avmm_csr_readdata[2]};

`ifdef ONCHIP_FLASH_LINE_BUF_EN
    logic fill_en, fill_last, inval_en;

    assign fill_en   = (state_q == RD_DATA) && avmm_data_readdatavalid;
    assign fill_last = (beat_q == CNT_W'(BURST_LEN - 1));
    assign inval_en  = (state_q == IDLE) && req_valid && req_ready && req_write;

    onchip_flash_line_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) u_line_buf (
        .clk_i         (clock),
        .rst_i         (reset),
        .lookup_addr_i (req_addr),
        .hit_o         (buf_hit),
        .rdata_o       (buf_rdata),
        .fill_en_i     (fill_en),
        .fill_idx_i    (beat_q),
        .fill_data_i   (avmm_data_readdata),
        .fill_last_i   (fill_last),
        .fill_tag_i    (addr_q),
        .inval_en_i    (inval_en),
        .inval_addr_i  (req_addr)
    );
`else
    assign buf_hit   = 1'b0;
    assign buf_rdata = '0;
`endif

    always_comb begin
        state_d              = state_q;
        beat_d               = beat_q;
        poll_d               = poll_q;
        err_d                = err_q;
        addr_d               = addr_q;
        wdata_d              = wdata_q;
        rdata_d              = rdata_q;
        req_ready            = 1'b0;
        rsp_valid            = 1'b0;
        rsp_rdata            = '0;
        rsp_error            = 1'b0;
        avmm_data_addr       = '0;
        avmm_data_read       = 1'b0;
        avmm_data_write      = 1'b0;
        avmm_data_writedata  = '0;
        avmm_data_burstcount = '0;
        avmm_csr_addr        = CSR_STATUS;
        avmm_csr_read        = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so every output reads 0 while reset is held.
                req_ready = !reset;
                if (req_valid && req_ready) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    beat_d  = '0;
                    poll_d  = '0;
                    if (req_write) begin
                        state_d = WR_REQ;
                    end else if (buf_hit) begin
                        rdata_d = buf_rdata;
                        state_d = RESP;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                avmm_data_read       = 1'b1;
                avmm_data_addr       = addr_q & ~OFF_MASK;
                avmm_data_burstcount = CNT_W'(BURST_LEN);
                if (!avmm_data_waitrequest) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (avmm_data_readdatavalid) begin
                    if (beat_q == CNT_W'(addr_q & OFF_MASK)) rdata_d = avmm_data_readdata;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == CNT_W'(BURST_LEN - 1)) state_d = RESP;
                end
            end
            WR_REQ: begin
                avmm_data_write     = 1'b1;
                avmm_data_addr      = addr_q;
                avmm_data_writedata = wdata_q;
                if (!avmm_data_waitrequest) state_d = WR_POLL;
            end
            WR_POLL: begin
                avmm_csr_read = 1'b1;
                state_d       = WR_WAIT;
            end
            WR_WAIT: begin
                if (avmm_csr_readdata[STATUS_BUSY_MSB:STATUS_BUSY_LSB] != 2'b00) begin
                    poll_d = poll_q + 1'b1;
                    if (poll_d >= PC_W'(POLL_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = WR_POLL;
                    end
                end else begin
                    err_d   = ~avmm_csr_readdata[STATUS_WS];
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_error = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            poll_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

endmodule

// File: tb/tb_onchip_flash_ctrl.sv
// Directed bench for onchip_flash_ctrl: a transaction table driven against a
// cycle-level flash/CSR responder, plus a mid-burst reset sequence.
module tb_onchip_flash_ctrl;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BL = 2;
    localparam int PT = 16;
`ifdef ONCHIP_FLASH_LINE_BUF_EN
    localparam bit HIT = 1'b1;
`else
    localparam bit HIT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic [AW-1:0] avmm_data_addr;
    logic          avmm_data_read;
    logic          avmm_data_write;
    logic [DW-1:0] avmm_data_writedata;
    logic [1:0]    avmm_data_burstcount;
    logic [DW-1:0] avmm_data_readdata = '0;
    logic          avmm_data_waitrequest = 1'b0;
    logic          avmm_data_readdatavalid = 1'b0;
    logic          avmm_csr_addr;
    logic          avmm_csr_read;
    logic [31:0]   avmm_csr_readdata = '0;

    int total = 0;
    int bad   = 0;

    onchip_flash_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BURST_LEN    (BL),
        .POLL_TIMEOUT (PT)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_write               (req_write),
        .req_addr                (req_addr),
        .req_wdata               (req_wdata),
        .rsp_valid               (rsp_valid),
        .rsp_rdata               (rsp_rdata),
        .rsp_error               (rsp_error),
        .avmm_data_addr          (avmm_data_addr),
        .avmm_data_read          (avmm_data_read),
        .avmm_data_write         (avmm_data_write),
        .avmm_data_writedata     (avmm_data_writedata),
        .avmm_data_burstcount    (avmm_data_burstcount),
        .avmm_data_readdata      (avmm_data_readdata),
        .avmm_data_waitrequest   (avmm_data_waitrequest),
        .avmm_data_readdatavalid (avmm_data_readdatavalid),
        .avmm_csr_addr           (avmm_csr_addr),
        .avmm_csr_read           (avmm_csr_read),
        .avmm_csr_readdata       (avmm_csr_readdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          write;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          wait_cyc;
        logic [31:0] beat0;
        logic [31:0] beat1;
        int          busy_polls;
        logic [31:0] busy_val;
        logic [31:0] final_status;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_bursts;
        logic [15:0] exp_baddr;
        int          exp_csr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        avmm_data_waitrequest   = 1'b0;
        avmm_data_readdatavalid = 1'b0;
        avmm_data_readdata      = '0;
        avmm_csr_readdata       = '0;
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int n, waits, beats, bursts, writes, csr_reads, polls, csr_addr_bad, lat;
        bit granted, csr_pend, got;
        logic [15:0] baddr, waddr;
        logic [1:0]  bc;
        logic [31:0] wdat, rd;
        logic        er;
        n = 0; waits = 0; beats = 0; bursts = 0; writes = 0; csr_reads = 0;
        polls = 0; csr_addr_bad = 0; lat = 0; granted = 0; csr_pend = 0; got = 0;
        baddr = '0; waddr = '0; bc = '0; wdat = '0; rd = '0; er = 1'b0;

        @(negedge clock);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        while (!got && n < 200) begin
            @(posedge clock);
            #1;
            n++;
            req_valid = 1'b0;
            idle_inputs();
            if (csr_pend) begin
                avmm_csr_readdata = (polls < v.busy_polls) ? v.busy_val : v.final_status;
                polls++;
                csr_pend = 0;
            end
            if (granted && beats < BL) begin
                avmm_data_readdatavalid = 1'b1;
                avmm_data_readdata      = (beats == 0) ? v.beat0 : v.beat1;
                beats++;
            end
            if (avmm_data_read) begin
                baddr = avmm_data_addr;
                bc    = avmm_data_burstcount;
                if (waits < v.wait_cyc) begin
                    avmm_data_waitrequest = 1'b1;
                    waits++;
                end else begin
                    bursts++;
                    granted = 1;
                end
            end
            if (avmm_data_write) begin
                waddr = avmm_data_addr;
                wdat  = avmm_data_writedata;
                if (waits < v.wait_cyc) begin
                    avmm_data_waitrequest = 1'b1;
                    waits++;
                end else begin
                    writes++;
                end
            end
            if (avmm_csr_read) begin
                csr_reads++;
                csr_pend = 1;
                if (avmm_csr_addr !== 1'b0) csr_addr_bad++;
            end
            if (rsp_valid) begin
                got = 1;
                lat = n;
                rd  = rsp_rdata;
                er  = rsp_error;
            end
        end
        chk({tag, " rsp_seen"}, 32'(got), 32'd1);
        chk({tag, " rdata"}, rd, v.exp_rdata);
        chk({tag, " error"}, 32'(er), 32'(v.exp_err));
        chk({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, " bursts"}, 32'(bursts), 32'(v.exp_bursts));
        chk({tag, " csr_reads"}, 32'(csr_reads), 32'(v.exp_csr));
        chk({tag, " csr_addr"}, 32'(csr_addr_bad), 32'd0);
        chk({tag, " writes"}, 32'(writes), v.write ? 32'd1 : 32'd0);
        if (v.exp_bursts > 0) begin
            chk({tag, " burst_addr"}, 32'(baddr), 32'(v.exp_baddr));
            chk({tag, " burstcount"}, 32'(bc), 32'(BL));
        end
        if (v.write) begin
            chk({tag, " write_addr"}, 32'(waddr), 32'(v.addr));
            chk({tag, " write_data"}, wdat, v.wdata);
        end
        @(posedge clock);
        #1;
        idle_inputs();
        chk({tag, " rsp_one_cycle"}, 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        vec_t post;
        //           wr addr      wdata         wt beat0         beat1         bp   busy   final  exp_rdata     err bursts        baddr     csr lat
        vecs[0]  = '{0, 16'h0011, 32'h0,        3, 32'hAAAA0000, 32'hBBBB1111, 0,   32'h0, 32'h0, 32'hBBBB1111, 0, 1,            16'h0010, 0,  7};
        vecs[1]  = '{0, 16'h0010, 32'h0,        0, 32'hAAAA0000, 32'hBBBB1111, 0,   32'h0, 32'h0, 32'hAAAA0000, 0, HIT ? 0 : 1,  16'h0010, 0,  HIT ? 1 : 4};
        vecs[2]  = '{1, 16'h0010, 32'h12345678, 2, 32'h0,        32'h0,        5,   32'h2, 32'h8, 32'h0,        0, 0,            16'h0,    6,  16};
        vecs[3]  = '{0, 16'h0010, 32'h0,        1, 32'hCCCC0000, 32'hDDDD1111, 0,   32'h0, 32'h0, 32'hCCCC0000, 0, 1,            16'h0010, 0,  5};
        vecs[4]  = '{0, 16'h0011, 32'h0,        0, 32'hCCCC0000, 32'hDDDD1111, 0,   32'h0, 32'h0, 32'hDDDD1111, 0, HIT ? 0 : 1,  16'h0010, 0,  HIT ? 1 : 4};
        vecs[5]  = '{1, 16'h0040, 32'hCAFEF00D, 0, 32'h0,        32'h0,        100, 32'h2, 32'h8, 32'h0,        1, 0,            16'h0,    16, 34};
        vecs[6]  = '{1, 16'h0041, 32'h0BADBEEF, 0, 32'h0,        32'h0,        0,   32'h0, 32'h0, 32'h0,        1, 0,            16'h0,    1,  4};
        vecs[7]  = '{0, 16'h0013, 32'h0,        0, 32'h11111111, 32'h22222222, 0,   32'h0, 32'h0, 32'h22222222, 0, 1,            16'h0012, 0,  4};
        vecs[8]  = '{1, 16'h0050, 32'h00C0FFEE, 0, 32'h0,        32'h0,        1,   32'h1, 32'h8, 32'h0,        0, 0,            16'h0,    2,  6};
        vecs[9]  = '{0, 16'h0012, 32'h0,        0, 32'h11111111, 32'h22222222, 0,   32'h0, 32'h0, 32'h11111111, 0, HIT ? 0 : 1,  16'h0012, 0,  HIT ? 1 : 4};
        vecs[10] = '{1, 16'h0050, 32'h5A5A5A5A, 0, 32'h0,        32'h0,        2,   32'h3, 32'hC, 32'h0,        0, 0,            16'h0,    3,  8};

        repeat (3) @(posedge clock);
        #1;
        chk("reset ctl", 32'({req_ready, rsp_valid, rsp_error, avmm_data_read,
                              avmm_data_write, avmm_csr_read, avmm_csr_addr}), 32'd0);
        chk("reset bus", rsp_rdata | avmm_data_writedata | 32'(avmm_data_addr)
                         | 32'(avmm_data_burstcount), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("ready after reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("v%0d", i), vecs[i]);
        end

        // Reset in the middle of a burst, with a stray beat after release.
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0031;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("mid rd_req", 32'(avmm_data_read), 32'd1);
        @(posedge clock);
        #1;
        avmm_data_readdatavalid = 1'b1;
        avmm_data_readdata      = 32'h99999999;
        @(posedge clock);
        #1;
        avmm_data_readdatavalid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid reset ctl", 32'({req_ready, rsp_valid, rsp_error, avmm_data_read,
                                  avmm_data_write, avmm_csr_read, avmm_csr_addr}), 32'd0);
        chk("mid reset bus", rsp_rdata | 32'(avmm_data_addr) | 32'(avmm_data_burstcount), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        avmm_data_readdatavalid = 1'b1;
        avmm_data_readdata      = 32'h77777777;
        @(posedge clock);
        #1;
        avmm_data_readdatavalid = 1'b0;
        chk("stray beat", 32'({rsp_valid, req_ready, avmm_data_read}), 32'b010);

        // Line 0x12 was buffered before the reset; it must now miss.
        post = '{0, 16'h0013, 32'h0, 0, 32'h5555AAAA, 32'h6666BBBB, 0, 32'h0, 32'h0,
                 32'h6666BBBB, 0, 1, 16'h0012, 0, 4};
        run_txn("post_reset", post);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onchip_flash_ctrl.md
Name: onchip_flash_ctrl

Overview:
Parametrised access controller in front of the on-chip flash IP (Avalon-MM data port plus CSR port). It gives the CPU/bootloader a simple valid/ready request/response channel. Reads are issued as fixed-length bursts into a tagged line buffer; programs are issued as word writes, followed by CSR status polling with a timeout. It sits between the core's memory fabric and the flash macro.

Parameters:
ADDR_WIDTH, 16, word address width of the flash data port
DATA_WIDTH, 32, data word width
BURST_LEN, 2, beats per read burst (power of two, 1..8); burstcount width = $clog2(BURST_LEN)+1
POLL_TIMEOUT, 4096, max CSR status polls per program before an error is reported

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_write  in  1  1=program, 0=read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  program data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_error  out  1  program failed or timed out
avmm_data_addr  out  ADDR_WIDTH  flash data address
avmm_data_read  out  1  burst read request
avmm_data_write  out  1  word write request
avmm_data_writedata  out  DATA_WIDTH  write data
avmm_data_burstcount  out  $clog2(BURST_LEN)+1  burst length
avmm_data_readdata  in  DATA_WIDTH  returned beat
avmm_data_waitrequest  in  1  flash stall
avmm_data_readdatavalid  in  1  beat valid
avmm_csr_addr  out  1  0=status, 1=control
avmm_csr_read  out  1  status read strobe
avmm_csr_readdata  in  32  status word; fixed read latency 1, no waitrequest

Behaviour:
- Reset: all outputs 0, FSM in IDLE, line buffer invalid, poll counter 0. Reset asserted mid-burst aborts the burst; any beats still arriving after reset release are ignored, because the FSM is in IDLE.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_POLL, WR_WAIT, RESP.
- IDLE: req_ready=1. Handshake is req_valid&req_ready; the request is captured in registers. Read hit (buffer enabled): rsp_valid on the next cycle with the buffered word; no flash access. Read miss goes to RD_REQ. Write goes to WR_REQ.
- RD_REQ: avmm_data_addr = req_addr aligned down to BURST_LEN, burstcount = BURST_LEN, read held high until the cycle waitrequest=0, then go to RD_DATA.
- RD_DATA: count readdatavalid beats 0..BURST_LEN-1 into the line buffer. After the last beat: tag set, valid=1, go to RESP with the requested word.
- WR_REQ: write/addr/writedata held until waitrequest=0, then go to WR_POLL. The line buffer is invalidated on entry if the tag matches the write address.
- WR_POLL: assert avmm_csr_read (csr_addr=0) for 1 cycle, then go to WR_WAIT. WR_WAIT samples readdata the next cycle.
  - busy=readdata[1:0]!=0: increment the counter and return to WR_POLL.
  - Idle: rsp_error = ~readdata[3] (write-successful bit), go to RESP.
  - Counter reaches POLL_TIMEOUT: rsp_error=1, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. req_ready=0 in every state other than IDLE.
- Total read-miss latency from accept: 1 + stall cycles + BURST_LEN beats + 1.
- Burst counter width is $clog2(BURST_LEN)+1. Address alignment is a mask of the low $clog2(BURST_LEN) bits.
- A readdatavalid arriving outside RD_DATA is ignored.

Optional Feature:
ONCHIP_FLASH_LINE_BUF_EN
- Defined: line buffer present, read hits served in 1 cycle, write-hit invalidation active.
- Undefined: no buffer or tag. Every read goes through RD_REQ/RD_DATA and returns only the requested beat. The FSM and all ports are unchanged.

Decomposition:
- Package onchip_flash_ctrl_pkg holds:
  - FSM state enum
  - CSR address constants (STATUS=0, CONTROL=1)
  - status bit positions (BUSY[1:0], WS=3)
  - burstcount width function
- One sub-module, onchip_flash_line_buf: BURST_LEN x DATA_WIDTH storage, tag, valid, hit compare and invalidate. It is instantiated only under the macro.

Test Plan:
- Read 0x0011 with BURST_LEN=2, waitrequest 3 cycles, beats 0xAAAA0000/0xBBBB1111 -> burst addr 0x0010, burstcount 2, rsp_rdata 0xBBBB1111, rsp_error 0.
- Immediate read 0x0010 (buffer enabled) -> rsp_valid 1 cycle after accept, 0xAAAA0000, no avmm_data_read.
- Program 0x0010 = 0x12345678, status busy=2 for 5 polls then 0x08 -> rsp_error 0, buffer invalidated; next read 0x0010 issues a new burst.
- Program with status stuck 0x02, POLL_TIMEOUT=16 -> exactly 16 csr reads, rsp_error 1.
- Program completing with status 0x00 (WS=0) -> rsp_error 1.
- Assert reset during RD_DATA after 1 beat -> all outputs 0, buffer invalid, stray beat ignored; next read completes correctly.
